// File: rtl/bcd_add_defs.sv
// rtl/bcd_add_defs.sv - shared state, phase and op codes for the BCD adder sequencer
// Contents:
//   main_state_e : top-level sequencer states
//   hs_state_e   : four-phase handshake engine states
//   op_e         : datapath operation index, selects which req/ack pair is active
//   PH_*         : user-visible phase codes driven on the phase output
package bcd_add_defs;

    typedef enum logic [3:0] {
        S_IDLE,
        S_HS_LOAD_A,
        S_HS_DISP_A,
        S_WAIT_A,
        S_HS_LOAD_B,
        S_HS_DISP_B,
        S_WAIT_B,
        S_HS_LS,
        S_WAIT_LS,
        S_HS_MS,
        S_WAIT_MS
    } main_state_e;

    typedef enum logic [1:0] {
        H_IDLE,
        H_PRE,
        H_REQ,
        H_REL
    } hs_state_e;

    typedef enum logic [2:0] {
        OP_LOAD_A  = 3'd0,
        OP_LOAD_B  = 3'd1,
        OP_DISP_A  = 3'd2,
        OP_DISP_B  = 3'd3,
        OP_DISP_LS = 3'd4,
        OP_DISP_MS = 3'd5
    } op_e;

    localparam logic [2:0] PH_IDLE = 3'd0;
    localparam logic [2:0] PH_A    = 3'd1;
    localparam logic [2:0] PH_B    = 3'd2;
    localparam logic [2:0] PH_LS   = 3'd3;
    localparam logic [2:0] PH_MS   = 3'd4;

endpackage

// File: rtl/bcd_req_ack_hs.sv
// rtl/bcd_req_ack_hs.sv - single-op four-phase req/ack handshake engine
// Optional feature macro: ACK_TIMEOUT_EN (per-state timeout, abort pulse).
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_start      : begin a handshake (accepted in H_IDLE or on the finishing cycle of H_REL)
//   i_ack        : acknowledge of the currently selected op
//   o_req        : registered request
//   o_busy       : registered, high in H_PRE/H_REQ/H_REL
//   o_done       : high in the cycle the handshake completes (H_REL sees ack low)
//   o_abort      : high in the cycle a timeout fires (always 0 without ACK_TIMEOUT_EN)
module bcd_req_ack_hs
    import bcd_add_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_ack,
    output logic o_req,
    output logic o_busy,
    output logic o_done,
    output logic o_abort
);

    if ((TIMEOUT_CYCLES < 1) || (TO_W < 1) || (TIMEOUT_CYCLES >= (1 << TO_W))) begin : g_bad_cfg
        $error("bcd_req_ack_hs: TO_W too narrow for TIMEOUT_CYCLES");
    end

    hs_state_e r_state;
    hs_state_e w_state_next;
    logic      w_timeout;

`ifdef ACK_TIMEOUT_EN
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

    logic [TO_W-1:0] r_cnt;

    // The entry edge loads 0, so the counter reaches TIMEOUT_CYCLES on the
    // edge where r_cnt is TO_LAST; that edge already drops req.
    assign w_timeout = (r_state != H_IDLE) && (r_cnt == TO_LAST);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (w_state_next != r_state) begin
            r_cnt <= '0;
        end else if (r_state != H_IDLE) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    assign o_abort = w_timeout;
    assign o_done  = (r_state == H_REL) && !i_ack && !w_timeout;

    always_comb begin
        w_state_next = r_state;
        if (w_timeout) begin
            w_state_next = H_IDLE;
        end else begin
            case (r_state)
                H_IDLE:  if (i_start) w_state_next = H_PRE;
                H_PRE:   if (!i_ack) w_state_next = H_REQ;
                H_REQ:   if (i_ack) w_state_next = H_REL;
                // Back-to-back ops chain straight into H_PRE of the next op.
                H_REL:   if (!i_ack) w_state_next = i_start ? H_PRE : H_IDLE;
                default: w_state_next = H_IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= H_IDLE;
            o_req   <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            o_req   <= (w_state_next == H_REQ);
            o_busy  <= (w_state_next != H_IDLE);
        end
    end

endmodule

// File: rtl/bcd_add_controller.sv
// rtl/bcd_add_controller.sv - enter-driven sequencer for the BCD adder datapath
// Optional feature macro: ACK_TIMEOUT_EN (handshake timeout, sticky error).
// Ports:
//   CLK, RST          : clock, asynchronous active-high reset
//   enter             : debounced single-cycle user pulse
//   *_ack             : datapath acknowledges, one per operation
//   load_a .. display_ms : datapath requests, at most one high
//   phase             : 0 idle, 1 A, 2 B, 3 LS, 4 MS
//   busy              : a handshake is in progress
//   error             : sticky timeout abort flag
module bcd_add_controller
    import bcd_add_defs::*;
#(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TO_W           = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       enter,
    input  logic       load_a_ack,
    input  logic       load_b_ack,
    input  logic       display_a_ack,
    input  logic       display_b_ack,
    input  logic       display_ls_ack,
    input  logic       display_ms_ack,
    output logic       load_a,
    output logic       load_b,
    output logic       display_a,
    output logic       display_b,
    output logic       display_ls,
    output logic       display_ms,
    output logic [2:0] phase,
    output logic       busy,
    output logic       error
);

    main_state_e r_state;
    op_e         r_op;
    op_e         w_op_next;
    logic [2:0]  r_phase;
    logic        w_start;
    logic        w_req;
    logic        w_ack;
    logic        w_busy;
    logic        w_done;
    logic        w_abort;

    bcd_req_ack_hs #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TO_W           (TO_W)
    ) u_hs (
        .i_clk   (CLK),
        .i_rst   (RST),
        .i_start (w_start),
        .i_ack   (w_ack),
        .o_req   (w_req),
        .o_busy  (w_busy),
        .o_done  (w_done),
        .o_abort (w_abort)
    );

    // Only the selected op's ack reaches the engine; acks on other lines are ignored.
    always_comb begin
        case (r_op)
            OP_LOAD_A:  w_ack = load_a_ack;
            OP_LOAD_B:  w_ack = load_b_ack;
            OP_DISP_A:  w_ack = display_a_ack;
            OP_DISP_B:  w_ack = display_b_ack;
            OP_DISP_LS: w_ack = display_ls_ack;
            OP_DISP_MS: w_ack = display_ms_ack;
            default:    w_ack = 1'b0;
        endcase
    end

    // Requests are the engine's registered req steered by the registered op index.
    assign load_a     = w_req && (r_op == OP_LOAD_A);
    assign load_b     = w_req && (r_op == OP_LOAD_B);
    assign display_a  = w_req && (r_op == OP_DISP_A);
    assign display_b  = w_req && (r_op == OP_DISP_B);
    assign display_ls = w_req && (r_op == OP_DISP_LS);
    assign display_ms = w_req && (r_op == OP_DISP_MS);
    assign busy       = w_busy;
    assign phase      = r_phase;

    // Start is decided in the same cycle so the op index, phase and engine
    // H_PRE entry all land on one edge.  Enter is only looked at in wait
    // states, where the engine is idle, so pulses while busy are dropped.
    always_comb begin
        w_start   = 1'b0;
        w_op_next = r_op;
        if (!w_abort) begin
            case (r_state)
                S_IDLE, S_WAIT_MS: if (enter) begin w_start = 1'b1; w_op_next = OP_LOAD_A;  end
                S_WAIT_A:          if (enter) begin w_start = 1'b1; w_op_next = OP_LOAD_B;  end
                S_WAIT_B:          if (enter) begin w_start = 1'b1; w_op_next = OP_DISP_LS; end
                S_WAIT_LS:         if (enter) begin w_start = 1'b1; w_op_next = OP_DISP_MS; end
                S_HS_LOAD_A:       if (w_done) begin w_start = 1'b1; w_op_next = OP_DISP_A; end
                S_HS_LOAD_B:       if (w_done) begin w_start = 1'b1; w_op_next = OP_DISP_B; end
                default: ;
            endcase
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
            r_op    <= OP_LOAD_A;
            r_phase <= PH_IDLE;
        end else begin
            r_op <= w_op_next;
            if (w_abort) begin
                r_state <= S_IDLE;
                r_phase <= PH_IDLE;
            end else begin
                case (r_state)
                    S_IDLE, S_WAIT_MS: if (enter) begin r_state <= S_HS_LOAD_A; r_phase <= PH_A; end
                    S_HS_LOAD_A:       if (w_done) r_state <= S_HS_DISP_A;
                    S_HS_DISP_A:       if (w_done) r_state <= S_WAIT_A;
                    S_WAIT_A:          if (enter) begin r_state <= S_HS_LOAD_B; r_phase <= PH_B; end
                    S_HS_LOAD_B:       if (w_done) r_state <= S_HS_DISP_B;
                    S_HS_DISP_B:       if (w_done) r_state <= S_WAIT_B;
                    S_WAIT_B:          if (enter) begin r_state <= S_HS_LS; r_phase <= PH_LS; end
                    S_HS_LS:           if (w_done) r_state <= S_WAIT_LS;
                    S_WAIT_LS:         if (enter) begin r_state <= S_HS_MS; r_phase <= PH_MS; end
                    S_HS_MS:           if (w_done) r_state <= S_WAIT_MS;
                    default: begin
                        r_state <= S_IDLE;
                        r_phase <= PH_IDLE;
                    end
                endcase
            end
        end
    end

`ifdef ACK_TIMEOUT_EN
    logic r_error;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_error <= 1'b0;
        end else if (w_abort) begin
            r_error <= 1'b1;
        end
    end

    assign error = r_error;
`else
    assign error = 1'b0;
`endif

endmodule

// File: tb/tb_bcd_add_controller.sv
// tb/tb_bcd_add_controller.sv - directed self-checking bench for bcd_add_controller
module tb_bcd_add_controller;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       enter = 1'b0;
    logic       load_a_ack, load_b_ack, display_a_ack, display_b_ack, display_ls_ack, display_ms_ack;
    logic       load_a, load_b, display_a, display_b, display_ls, display_ms;
    logic [2:0] phase;
    logic       busy, error;

    logic [5:0] reqv;
    logic [5:0] ackv = '0;
    logic [5:0] frc_en = '0;
    logic [5:0] frc_val = '0;

    int n_tests = 0;
    int n_fail  = 0;

    // Request bit order: load_a, load_b, display_a, display_b, display_ls, display_ms
    assign reqv = {display_ms, display_ls, display_b, display_a, load_b, load_a};
    assign {display_ms_ack, display_ls_ack, display_b_ack, display_a_ack, load_b_ack, load_a_ack} = ackv;

    bcd_add_controller #(
        .TIMEOUT_CYCLES (10),
        .TO_W           (8)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .enter          (enter),
        .load_a_ack     (load_a_ack),
        .load_b_ack     (load_b_ack),
        .display_a_ack  (display_a_ack),
        .display_b_ack  (display_b_ack),
        .display_ls_ack (display_ls_ack),
        .display_ms_ack (display_ms_ack),
        .load_a         (load_a),
        .load_b         (load_b),
        .display_a      (display_a),
        .display_b      (display_b),
        .display_ls     (display_ls),
        .display_ms     (display_ms),
        .phase          (phase),
        .busy           (busy),
        .error          (error)
    );

    always #5 CLK = ~CLK;

    // Responsive datapath: each ack is its req delayed by one cycle unless forced.
    always @(posedge CLK) begin
        for (int i = 0; i < 6; i++) begin
            ackv[i] <= frc_en[i] ? frc_val[i] : reqv[i];
        end
    end

    // Request monitor, sampled shortly after each rising edge.
    logic [5:0] mon_prev = '0;
    int         mon_len[6];
    int         rise_q[$];
    int         rise_ph_q[$];
    int         len_q[$];
    int         onehot_viol = 0;

    always @(posedge CLK) begin
        #2;
        for (int i = 0; i < 6; i++) begin
            if (reqv[i] && !mon_prev[i]) begin
                rise_q.push_back(i);
                rise_ph_q.push_back(int'(phase));
                mon_len[i] = 1;
            end else if (reqv[i]) begin
                mon_len[i] = mon_len[i] + 1;
            end else if (mon_prev[i]) begin
                len_q.push_back(mon_len[i]);
            end
        end
        if ($countones(reqv) > 1) onehot_viol = onehot_viol + 1;
        mon_prev = reqv;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge CLK);
    endtask

    task automatic pulse_enter();
        enter = 1'b1;
        @(negedge CLK);
        enter = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int k;
        k = 0;
        while (busy !== 1'b0 && k < 200) begin
            @(negedge CLK);
            k++;
        end
        check(tag, 32'(busy), 32'd0);
    endtask

    task automatic clear_mon();
        rise_q.delete();
        rise_ph_q.delete();
        len_q.delete();
    endtask

    int exp_order[6] = '{0, 2, 1, 3, 4, 5};
    int exp_phase[6] = '{1, 1, 2, 2, 3, 4};

    initial begin
        int k;

        // Reset state
        tick(3);
        check("rst_reqs", 32'(reqv), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_phase", 32'(phase), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        RST = 1'b0;
        tick(2);

        // Sticky ack on load_a: request must wait for ack to drop
        frc_en[0] = 1'b1;
        frc_val[0] = 1'b1;
        tick(2);
        check("sticky_ack_high", 32'(load_a_ack), 32'd1);
        pulse_enter();
        check("sticky_phase", 32'(phase), 32'd1);
        check("sticky_busy", 32'(busy), 32'd1);
        check("sticky_req_pre", 32'(load_a), 32'd0);
        tick(3);
        check("sticky_req_hold", 32'(load_a), 32'd0);
        frc_en[0] = 1'b0;
        k = 0;
        do begin
            @(negedge CLK);
            k++;
        end while (load_a_ack !== 1'b0 && k < 10);
        check("sticky_ack_low", 32'(load_a_ack), 32'd0);
        check("sticky_req_still_low", 32'(load_a), 32'd0);
        tick(1);
        check("sticky_req_rise", 32'(load_a), 32'd1);

        // Asynchronous reset in H_REQ of load_a
        RST = 1'b1;
        #1;
        check("rst_async_req", 32'(load_a), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        check("rst_async_phase", 32'(phase), 32'd0);
        tick(1);
        RST = 1'b0;
        tick(2);
        check("rst_rel_reqs", 32'(reqv), 32'd0);
        check("rst_rel_busy", 32'(busy), 32'd0);
        check("rst_rel_phase", 32'(phase), 32'd0);

        // Full cycle with the responsive ack model
        clear_mon();
        pulse_enter();
        check("cyc_phase_a", 32'(phase), 32'd1);
        check("cyc_a_pre", 32'(load_a), 32'd0);
        tick(1);
        check("cyc_a_req", 32'(load_a), 32'd1);
        wait_idle("cyc_idle_a");
        check("cyc_settle_a", 32'(phase), 32'd1);
        pulse_enter();
        check("cyc_phase_b", 32'(phase), 32'd2);
        wait_idle("cyc_idle_b");
        pulse_enter();
        check("cyc_phase_ls", 32'(phase), 32'd3);
        wait_idle("cyc_idle_ls");
        pulse_enter();
        check("cyc_phase_ms", 32'(phase), 32'd4);
        wait_idle("cyc_idle_ms");
        check("cyc_nreq", 32'(rise_q.size()), 32'd6);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("cyc_order%0d", i), 32'(rise_q[i]), 32'(exp_order[i]));
            check($sformatf("cyc_len%0d", i), 32'(len_q[i]), 32'd2);
            check($sformatf("cyc_ph%0d", i), 32'(rise_ph_q[i]), 32'(exp_phase[i]));
        end

        // Wrap from WAIT_MS, then enter during display_a is ignored
        clear_mon();
        pulse_enter();
        check("wrap_phase", 32'(phase), 32'd1);
        tick(1);
        check("wrap_req", 32'(load_a), 32'd1);
        k = 0;
        while (display_a !== 1'b1 && k < 50) begin
            @(negedge CLK);
            k++;
        end
        check("busy_disp_a_seen", 32'(display_a), 32'd1);
        pulse_enter();
        wait_idle("busy_idle");
        check("busy_enter_phase", 32'(phase), 32'd1);
        check("busy_enter_nreq", 32'(rise_q.size()), 32'd2);

`ifdef ACK_TIMEOUT_EN
        // load_b never acknowledged: abort after 10 cycles in H_REQ
        frc_en[1] = 1'b1;
        frc_val[1] = 1'b0;
        pulse_enter();
        check("to_phase_b", 32'(phase), 32'd2);
        wait_idle("to_idle");
        check("to_req_low", 32'(load_b), 32'd0);
        check("to_error", 32'(error), 32'd1);
        check("to_phase_idle", 32'(phase), 32'd0);
        check("to_op", 32'(rise_q[2]), 32'd1);
        check("to_len", 32'(len_q[2]), 32'd10);
        pulse_enter();
        check("to_restart_phase", 32'(phase), 32'd1);
        check("to_restart_error", 32'(error), 32'd1);
        tick(1);
        check("to_restart_req", 32'(load_a), 32'd1);
        frc_en[1] = 1'b0;
        wait_idle("to_restart_idle");
        check("to_error_sticky", 32'(error), 32'd1);
`else
        pulse_enter();
        check("after_busy_phase_b", 32'(phase), 32'd2);
        wait_idle("after_busy_idle");
        check("after_busy_op", 32'(rise_q[2]), 32'd1);
        check("after_busy_len", 32'(len_q[2]), 32'd2);
        check("error_tied_low", 32'(error), 32'd0);
`endif

        check("req_onehot", 32'(onehot_viol), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

endmodule

// File: doc/bcd_add_controller.md
Name: bcd_add_controller

Overview:
- Sequencer FSM that drives the request/acknowledge interface of bcd_add_datapath.
- Steps the user through four phases, one per `enter` press: load operand A, load operand B, show sum LS digit, show sum MS digit.
- Every datapath operation uses a four-phase req/ack handshake.
- Sits between the board push-button logic and the datapath; owns no arithmetic.

Parameters:
- TIMEOUT_CYCLES, 255, cycles allowed per handshake phase before abort (used only with ACK_TIMEOUT_EN).
- TO_W, 8, width of the timeout counter; must satisfy 2^TO_W > TIMEOUT_CYCLES.

Ports:
- CLK  in  1  system clock; all state changes on posedge.
- RST  in  1  asynchronous, active-high reset.
- enter  in  1  single-cycle pulse, already synchronised and debounced upstream.
- load_a_ack, load_b_ack, display_a_ack, display_b_ack, display_ls_ack, display_ms_ack  in  1 each  datapath acknowledges.
- load_a, load_b, display_a, display_b, display_ls, display_ms  out  1 each  datapath requests; at most one high in any cycle.
- phase  out  3  current user phase: 0=idle, 1=A, 2=B, 3=LS, 4=MS.
- busy  out  1  high while any handshake is in progress.
- error  out  1  sticky abort flag (ACK_TIMEOUT_EN only; otherwise tied 0).

Behaviour:
- Reset (async, RST=1):
  - all request outputs 0, busy=0, error=0, phase=0, FSM=IDLE.
  - Reset mid-handshake drops the request in the same instant; the acknowledge is not waited for.
- Handshake sub-FSM, one instance per operation (op = req/ack pair):
  - H_PRE: wait until the op's ack=0. Protects against stale or sticky acks.
  - H_REQ: req=1; hold until ack=1 is sampled.
  - H_REL: req=0; wait until ack=0.
  - Then done.
  - busy=1 in all three states.
  - Minimum 3 cycles per op: req rises the cycle after H_PRE sees ack=0; it falls the cycle after ack=1 is sampled.
- Main FSM sequence:
  - IDLE, then on enter: HS(load_a), then HS(display_a), then WAIT_A.
  - WAIT_A, then on enter: HS(load_b), then HS(display_b), then WAIT_B.
  - WAIT_B, then on enter: HS(display_ls), then WAIT_LS.
  - WAIT_LS, then on enter: HS(display_ms), then WAIT_MS.
  - WAIT_MS, then on enter: back to the load_a handshake, starting a new computation.
- phase updates on the same edge the corresponding handshake starts.
- enter pulses arriving while busy=1 are ignored; they are not queued.
- A spurious ack whose req is low does not change state except in H_PRE/H_REL, where it is simply waited out.
- An ack on a different op's line is ignored.
- Output encoding: requests are registered outputs; no combinational path from ack to req.

Optional Feature:
- Macro: ACK_TIMEOUT_EN.
- When defined:
  - A counter of width TO_W clears on every handshake state entry and increments each cycle spent in H_PRE, H_REQ or H_REL.
  - When it reaches TIMEOUT_CYCLES: all requests go to 0 next cycle, error=1 (sticky until RST), FSM returns to IDLE, phase=0.
  - enter from IDLE still restarts the sequence; error stays set.
- When undefined: no counter logic, error is driven 0, handshakes wait indefinitely.

Decomposition:
- Shared package/header bcd_add_defs: main-state localparams, phase codes (PH_IDLE..PH_MS), op index codes (OP_LOAD_A..OP_DISP_MS).
- One natural sub-module: bcd_req_ack_hs, a single-op four-phase handshake engine (start in, req out, ack in, done/busy out).
  - The controller instantiates one engine and muxes it onto the six req/ack pairs by op index.

Test Plan:
- Reset behaviour: assert RST mid-H_REQ of load_a -> load_a=0 asynchronously; phase=0, busy=0 after release.
- Full cycle, responsive ack model (ack follows req after 1 cycle): 4 enter pulses -> request order load_a, display_a, load_b, display_b, display_ls, display_ms; each req high exactly 2 cycles; phase sequence 1,2,3,4.
- Sticky ack: hold load_a_ack=1 at IDLE, pulse enter -> load_a stays 0 until ack is driven 0, then rises next cycle.
- Enter while busy: pulse enter during the display_a handshake -> ignored; FSM settles in WAIT_A, phase=1.
- Wrap: fifth enter from WAIT_MS -> load_a handshake restarts, phase=1.
- ACK_TIMEOUT_EN, TIMEOUT_CYCLES=10, ack never rises on load_b -> load_b drops after 10 cycles in H_REQ, error=1, phase=0; subsequent enter restarts with error still 1.
